// File: rtl/monopix_rx_if.sv
// Arbiter-side FIFO port of the MONOPIX receiver: first-word-fall-through
// head word plus empty flag, popped by FIFO_READ.
interface monopix_rx_if;
  logic        FIFO_READ;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;

  modport master (output FIFO_READ, input FIFO_EMPTY, input FIFO_DATA);
  modport slave  (input FIFO_READ, output FIFO_EMPTY, output FIFO_DATA);
endinterface

// File: rtl/monopix_rx.sv
// MONOPIX hit readout: on TOKEN freeze the matrix, strobe READ, shift in one
// serial hit word per READ and buffer tagged words in a FWFT FIFO.
module monopix_rx #(
  parameter int unsigned DATA_BITS    = 24,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [3:0]  IDENTIFIER   = 4'b0001,
  parameter int unsigned FREEZE_DELAY = 2,
  parameter int unsigned READ_WIDTH   = 2,
  parameter int unsigned READ_GAP     = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        TOKEN,
  input  logic        DATA,
  output logic        FREEZE,
  output logic        READ,
  output logic        SER_CLK_EN,
  output logic        BUSY,
  output logic [7:0]  LOST_COUNT,
  monopix_rx_if.slave fifo_if
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_FRZ, S_RD, S_GAP, S_SHIFT, S_STORE, S_UNFRZ
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        limit;
  logic                 last;
  logic                 tok_meta_q, tok_s_q;
  logic                 freeze_q, read_q, sclk_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [7:0]           lost_q;
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [31:0]          mem_q [FIFO_DEPTH];
  logic                 shift_en, store_evt, push, drop, pop;
  logic                 fifo_empty, fifo_full;
  logic [31:0]          word;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tok_meta_q <= 1'b0;
      tok_s_q    <= 1'b0;
    end else begin
      tok_meta_q <= TOKEN;
      tok_s_q    <= tok_meta_q;
    end
  end

  // Each timed state lasts 'limit' cycles; cnt_q restarts on every state change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FRZ:   limit = CW'(FREEZE_DELAY);
      S_RD:    limit = CW'(READ_WIDTH);
      S_GAP:   limit = CW'(READ_GAP);
      S_SHIFT: limit = CW'(DATA_BITS);
      default: limit = CW'(1);
    endcase
    last = (cnt_q == limit - CW'(1));
    case (state_q)
      S_IDLE:  if (ENABLE && tok_s_q) state_d = S_FRZ;
      S_FRZ:   if (last) state_d = S_RD;
      S_RD:    if (last) state_d = S_GAP;
      S_GAP:   if (last) state_d = S_SHIFT;
      S_SHIFT: if (last) state_d = S_STORE;
      S_STORE: state_d = (ENABLE && tok_s_q) ? S_RD : S_UNFRZ;
      S_UNFRZ: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    else                                         cnt_d = cnt_q + CW'(1);
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // The word is complete on the edge entering STORE, so it is written there;
  // fullness uses the pre-edge count, a same-cycle pop does not make room.
  assign shift_en  = (state_d == S_SHIFT);
  assign store_evt = (state_q == S_SHIFT) && (state_d == S_STORE);
  assign push      = store_evt && !fifo_full;
  assign drop      = store_evt && fifo_full;
  assign pop       = fifo_if.FIFO_READ && !fifo_empty;
  assign word      = {IDENTIFIER, 28'(shift_q)};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      freeze_q <= 1'b0;
      read_q   <= 1'b0;
      sclk_q   <= 1'b0;
      shift_q  <= '0;
      lost_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      freeze_q <= state_d inside {S_FRZ, S_RD, S_GAP, S_SHIFT, S_STORE};
      read_q   <= (state_d == S_RD);
      sclk_q   <= shift_en;
      if (shift_en) shift_q <= (shift_q << 1) | DATA_BITS'(DATA);
      if (drop && lost_q != 8'hFF) lost_q <= lost_q + 8'd1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= word;
  end

  assign FREEZE             = freeze_q;
  assign READ               = read_q;
  assign SER_CLK_EN         = sclk_q;
  assign BUSY               = (state_q != S_IDLE);
  assign LOST_COUNT         = lost_q;
  assign fifo_if.FIFO_EMPTY = fifo_empty;
  assign fifo_if.FIFO_DATA  = fifo_empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: doc/monopix_rx.md
# monopix_rx

Parametrised MONOPIX hit readout for the MIO top. It replaces the tied-off READ/FREEZE outputs and the always-empty FE FIFO slot of the arbiter. On a chip TOKEN it freezes the matrix, pulses READ, and clocks out one serial hit word per READ. Each hit is tagged and buffered in an internal first-word-fall-through FIFO whose FIFO_READ/FIFO_EMPTY/FIFO_DATA side plugs straight into one rrp_arbiter input.

## Interface
- DATA_BITS, 24: serial hit-word length; legal range 1..28.
- FIFO_DEPTH, 16: buffer depth in words; power of 2, at least 2.
- IDENTIFIER, 4'b0001: tag placed in FIFO_DATA[31:28].
- FREEZE_DELAY, 2: cycles FREEZE is held before the first READ; at least 1.
- READ_WIDTH, 2: cycles READ is held high; at least 1.
- READ_GAP, 1: cycles between READ falling and the first serial sample; at least 1.

Ports:
- CLK in 1: single clock; everything is registered on the rising edge.
- RST in 1: asynchronous, active-high reset.
- ENABLE in 1: readout enable, level.
- TOKEN in 1: chip token; asynchronous, synchronised internally with 2 flops.
- DATA in 1: chip serial data, sampled on CLK during SHIFT.
- FREEZE out 1: registered, matrix freeze.
- READ out 1: registered, read strobe.
- SER_CLK_EN out 1: registered; high during SHIFT. Gates the chip output clock.
- BUSY out 1: high whenever the FSM is not in IDLE.
- FIFO_READ in 1: pop request from the arbiter.
- FIFO_EMPTY out 1: high when the buffer is empty.
- FIFO_DATA out 32: head word, valid while FIFO_EMPTY is low.
- LOST_COUNT out 8: saturating count of hits dropped on full.

## Operation
- Reset values: FREEZE=0, READ=0, SER_CLK_EN=0, BUSY=0, FIFO_EMPTY=1, FIFO_DATA=0, LOST_COUNT=0. FSM returns to IDLE, FIFO pointers clear, shift register clears.
- Reset mid-operation aborts immediately. The partial word is discarded and not counted as lost.
- FSM states: IDLE, FRZ, RD, GAP, SHIFT, STORE, UNFRZ.
  - IDLE: go to FRZ when ENABLE=1 and synchronised TOKEN (TOK_S)=1.
  - FRZ: FREEZE=1 for FREEZE_DELAY cycles, then go to RD.
  - RD: READ=1 for READ_WIDTH cycles, then go to GAP.
  - GAP: wait READ_GAP cycles, then go to SHIFT.
  - SHIFT: SER_CLK_EN=1 for exactly DATA_BITS cycles. DATA is shifted in MSB first, one bit per cycle. Then go to STORE.
  - STORE: one cycle. Push the word if count < FIFO_DEPTH; otherwise increment LOST_COUNT, saturating at 255. Next state is RD if TOK_S=1 and ENABLE=1, else UNFRZ.
  - UNFRZ: FREEZE=0 for one cycle, then go to IDLE. FSM does not re-enter FRZ in the same cycle.
- FREEZE stays high continuously from FRZ through the last STORE. There is no unfreeze between consecutive hits.
- ENABLE falling mid-readout: the current word completes and is stored, then the FSM goes to UNFRZ. ENABLE is only sampled in IDLE and STORE.
- Word format: [31:28]=IDENTIFIER, [27:DATA_BITS]=0, [DATA_BITS-1:0]=shifted data. The first-sampled bit lands in bit DATA_BITS-1.
- FIFO is first-word-fall-through:
  - FIFO_DATA shows the head word while FIFO_EMPTY=0.
  - FIFO_READ with FIFO_EMPTY=0 pops; the next word (or FIFO_EMPTY=1) appears after that edge.
  - FIFO_READ while empty is ignored.
  - Full is judged on the count before the edge. A simultaneous pop does not free space for the same-cycle STORE, so the word is dropped.
  - Simultaneous push and pop when not full and not empty: count unchanged.
  - Push into an empty FIFO: FIFO_EMPTY falls on the edge after STORE.
- Pointer widths are log2(FIFO_DEPTH)+1 so full/empty are unambiguous across wrap-around.

## Timing
- Define T0 as the first edge where TOKEN is sampled high. TOK_S is valid after T0+1, and FRZ is entered at edge T0+2, so FREEZE is high from T0+2.
- First READ high edge: T0+2+FREEZE_DELAY.
- First DATA sample edge: T0+2+FREEZE_DELAY+READ_WIDTH+READ_GAP.
- STORE edge: first DATA sample edge + DATA_BITS. FIFO_EMPTY falls on that same edge.
- With default parameters: FREEZE high at T0+2, READ high at T0+4..T0+5, samples at T0+7..T0+30, STORE at T0+31, FIFO_EMPTY low after T0+31.
- Hit-to-hit period with TOKEN held high: READ_WIDTH+READ_GAP+DATA_BITS+1 cycles (28 with defaults).
- FREEZE falls at the edge after the last STORE (UNFRZ) and remains low for at least 1 cycle before any new FRZ.

## Test plan
- Single hit, defaults: TOKEN high T0..T0+20, DATA stream 0xA5C3F0 MSB first from T0+7 → FREEZE high from T0+2, READ high at T0+4..T0+5, FIFO_DATA=0x10A5C3F0 after T0+31, FREEZE low at T0+32, BUSY low at T0+33.
- Three hits, TOKEN held through all of them → 3 words in order, READ pulses 28 cycles apart, FREEZE continuous; after 3 pops FIFO_EMPTY=1.
- Overflow, FIFO_DEPTH=4, 6 hits, no FIFO_READ → 4 words kept, LOST_COUNT=2, FIFO_EMPTY=0. Then pop 4 → FIFO_EMPTY=1 and data in first-in-first-out order. Also: push and pop on the same cycle while full → word dropped, LOST_COUNT increments.
- ENABLE drops during SHIFT of the first hit with TOKEN still high → that word is stored, the FSM goes to UNFRZ, and there is no second READ.
- RST pulse during SHIFT → all outputs at reset values asynchronously, FIFO_EMPTY=1, no word stored. A TOKEN after release starts a clean cycle at T0+2.
- Wrap-around: DATA_BITS=28, FIFO_DEPTH=2; 5 hits each popped 3 cycles after push → every word correct, LOST_COUNT=0.
